// File: rtl/pixel_byte_fifo.sv
// Pixel word FIFO feeding a byte serializer for the UART path.
// Words enter whole; bytes leave MSB first with a valid/ready handshake.
module pixel_byte_fifo #(
  parameter int PixelBitWidth = 16,
  parameter int Depth         = 16
) (
  input  logic                       p_clk,
  input  logic                       RST,
  input  logic [PixelBitWidth-1:0]   i_data,
  input  logic                       i_valid,
  output logic [7:0]                 o_byte,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(Depth):0]     o_count,
  output logic                       o_overflow
);

  localparam int AW     = $clog2(Depth);
  localparam int CW     = AW + 1;
  localparam int NBytes = PixelBitWidth / 8;
  localparam int IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBytes - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [PixelBitWidth-1:0] mem [Depth];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [CW-1:0]            count;
  state_t                   state;
  logic [PixelBitWidth-1:0] shreg;
  logic [IdxW-1:0]          byte_idx;

  logic full;
  logic empty;
  logic wr_en;
  logic last_xfer;
  logic pop;

  assign full      = (count == CW'(Depth));
  assign empty     = (count == '0);
  assign wr_en     = i_valid && !full;
  assign last_xfer = (state == SEND) && i_ready && (byte_idx == LastIdx);
  // A word leaves the FIFO either into an idle serializer or back-to-back
  // with the final byte of the previous word, so the byte stream has no gap.
  assign pop       = !empty && ((state == IDLE) || last_xfer);

  assign o_count = count;
  assign o_byte  = shreg[PixelBitWidth-1 -: 8];

  always_ff @(posedge p_clk) begin
    if (wr_en) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge p_clk or negedge RST) begin
    if (!RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
      if (i_valid && full) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge p_clk or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      shreg    <= '0;
      byte_idx <= '0;
      o_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= mem[rd_ptr];
            byte_idx <= '0;
            o_valid  <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (i_ready) begin
            if (byte_idx == LastIdx) begin
              byte_idx <= '0;
              if (pop) begin
                shreg <= mem[rd_ptr];
              end else begin
                shreg   <= '0;
                o_valid <= 1'b0;
                state   <= IDLE;
              end
            end else begin
              shreg    <= {shreg[PixelBitWidth-9:0], 8'h00};
              byte_idx <= byte_idx + IdxW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_byte_fifo.sv
// Bench for pixel_byte_fifo: directed scenarios plus a randomized run
// compared against a queue-based model of the word/byte stream.
module tb_pixel_byte_fifo;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;

  logic          p_clk = 1'b0;
  logic          RST = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic          i_valid = 1'b0;
  logic [7:0]    o_byte;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [CW-1:0] o_count;
  logic          o_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mq[$];
  logic [7:0]   bq[$];
  bit           m_ovf = 1'b0;

  pixel_byte_fifo #(.PixelBitWidth(W), .Depth(D)) dut (
    .p_clk(p_clk), .RST(RST), .i_data(i_data), .i_valid(i_valid),
    .o_byte(o_byte), .o_valid(o_valid), .i_ready(i_ready),
    .o_count(o_count), .o_overflow(o_overflow)
  );

  always #5 p_clk = ~p_clk;

  // One clock: apply inputs, advance the model, return #1 after the edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    int pre;
    logic [W-1:0] w;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    if (RST) begin
      pre = mq.size();
      if (bq.size() > 0 && r) void'(bq.pop_front());
      if (pre > 0 && bq.size() == 0) begin
        w = mq.pop_front();
        for (int k = 0; k < W / 8; k++) bq.push_back(w[(W - 1 - 8 * k) -: 8]);
      end
      if (v) begin
        if (pre < D) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    @(posedge p_clk);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    mq.delete();
    bq.delete();
    m_ovf = 1'b0;
    repeat (2) @(posedge p_clk);
    #1;
    RST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (o_valid !== 1'b0 || o_byte !== 8'h00 || o_count !== '0 || o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got valid=%0b byte=%h count=%0d ovf=%0b want 0/00/0/0",
               o_valid, o_byte, o_count, o_overflow);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 16'hA55A, 1'b1);
    n_checks++;
    if (o_count !== CW'(1) || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_n count=%0d valid=%0b want 1/0", o_count, o_valid);
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (o_valid !== 1'b1 || o_byte !== 8'hA5 || o_count !== '0) begin
      n_fail++;
      $display("FAIL single_b0 valid=%0b byte=%h count=%0d want 1/a5/0", o_valid, o_byte, o_count);
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (o_valid !== 1'b1 || o_byte !== 8'h5A) begin
      n_fail++;
      $display("FAIL single_b1 valid=%0b byte=%h want 1/5a", o_valid, o_byte);
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end valid=%0b want 0", o_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_reset();
    step(1'b1, 16'h1234, 1'b1);
    step(1'b1, 16'h5678, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_byte !== exp_b[k]) begin
        n_fail++;
        $display("FAIL b2b_byte%0d valid=%0b byte=%h want 1/%h", k, o_valid, o_byte, exp_b[k]);
      end
      step(1'b0, '0, 1'b1);
    end
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end valid=%0b want 0", o_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(1'b1, 16'h1234, 1'b0);
    step(1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_byte !== 8'h12) begin
        n_fail++;
        $display("FAIL stall_hold%0d valid=%0b byte=%h want 1/12", k, o_valid, o_byte);
      end
      step(1'b0, '0, 1'b0);
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (o_valid !== 1'b1 || o_byte !== 8'h34) begin
      n_fail++;
      $display("FAIL stall_release valid=%0b byte=%h want 1/34", o_valid, o_byte);
    end
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_overflow();
    logic [7:0] got[$];
    logic [W-1:0] w;
    do_reset();
    for (int i = 0; i < D + 2; i++) step(1'b1, W'(16'hC000 + i * 16'h0101), 1'b0);
    n_checks++;
    if (o_count !== CW'(D) || o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_full count=%0d ovf=%0b want %0d/1", o_count, o_overflow, D);
    end
    for (int c = 0; c < 2 * (D + 3) && got.size() < 2 * (D + 2); c++) begin
      if (o_valid) got.push_back(o_byte);
      step(1'b0, '0, 1'b1);
    end
    n_checks++;
    if (got.size() != 2 * (D + 1)) begin
      n_fail++;
      $display("FAIL ovf_bytecount got=%0d want %0d", got.size(), 2 * (D + 1));
    end
    for (int i = 0; i < D + 1 && 2 * i + 1 < got.size(); i++) begin
      w = W'(16'hC000 + i * 16'h0101);
      n_checks++;
      if ({got[2 * i], got[2 * i + 1]} !== w) begin
        n_fail++;
        $display("FAIL ovf_word%0d got=%h want %h", i, {got[2 * i], got[2 * i + 1]}, w);
      end
    end
    n_checks++;
    if (o_overflow !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_sticky ovf=%0b valid=%0b want 1/0", o_overflow, o_valid);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < D + 1; i++) step(1'b1, W'(i), 1'b0);
    n_checks++;
    if (o_count !== CW'(D) || o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_pre count=%0d ovf=%0b want %0d/0", o_count, o_overflow, D);
    end
    step(1'b0, '0, 1'b1);
    step(1'b1, 16'hDEAD, 1'b1);
    n_checks++;
    if (o_count !== CW'(D - 1) || o_overflow !== 1'b1 || o_valid !== 1'b1 || o_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL fullpop count=%0d ovf=%0b valid=%0b byte=%h want %0d/1/1/00",
               o_count, o_overflow, o_valid, o_byte, D - 1);
    end
  endtask

  task automatic test_reset_midword();
    do_reset();
    step(1'b1, 16'h1234, 1'b1);
    step(1'b1, 16'h5678, 1'b1);
    RST = 1'b0;
    mq.delete();
    bq.delete();
    m_ovf = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_byte !== 8'h00 || o_count !== '0 || o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async valid=%0b byte=%h count=%0d ovf=%0b want 0/00/0/0",
               o_valid, o_byte, o_count, o_overflow);
    end
    i_valid = 1'b1;
    i_data  = 16'hBEEF;
    @(posedge p_clk);
    #1;
    RST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, 1'b1);
      n_checks++;
      if (o_valid !== 1'b0 || o_count !== '0) begin
        n_fail++;
        $display("FAIL rst_quiet%0d valid=%0b count=%0d want 0/0", k, o_valid, o_count);
      end
    end
    step(1'b1, 16'hABCD, 1'b1);
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (o_valid !== 1'b1 || o_byte !== 8'hAB) begin
      n_fail++;
      $display("FAIL rst_newword valid=%0b byte=%h want 1/ab", o_valid, o_byte);
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    logic v;
    logic r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(0, 99) < ((c / 150) % 2 == 0 ? 70 : 30));
      r = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 40 : 90));
      step(v, W'($urandom), r);
      n_checks++;
      if (o_valid !== (bq.size() > 0) || o_count !== CW'(mq.size()) || o_overflow !== m_ovf ||
          (bq.size() > 0 && o_byte !== bq[0])) begin
        n_fail++;
        $display("FAIL rand_cyc%0d valid=%0b byte=%h count=%0d ovf=%0b want %0b/%h/%0d/%0b",
                 c, o_valid, o_byte, o_count, o_overflow, bq.size() > 0,
                 (bq.size() > 0) ? bq[0] : 8'h00, mq.size(), m_ovf);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_full_pop();
    test_reset_midword();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_byte_fifo.md
PIXEL_BYTE_FIFO -- requirements
Module: pixel_byte_fifo

Interface
REQ-001 SHALL have parameter PixelBitWidth, default 16, meaning pixel word width in bits; a multiple of 8, at least 16.
REQ-002 SHALL have parameter Depth, default 16, meaning FIFO capacity in pixel words; a power of 2, at least 2.
REQ-003 SHALL have port p_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_data, input, PixelBitWidth bits: pixel word from the upstream VGA capture stage (Y+U/V pair, MSB first).
REQ-006 SHALL have port i_valid, input, 1 bit: single-cycle strobe, driven by the capture stage ready output, qualifying i_data.
REQ-007 SHALL have port o_byte, output, 8 bits: byte presented to the downstream UART transmitter.
REQ-008 SHALL have port o_valid, output, 1 bit: o_byte holds a valid byte.
REQ-009 SHALL have port i_ready, input, 1 bit: downstream accepts o_byte this cycle.
REQ-010 SHALL have port o_count, output, $clog2(Depth)+1 bits: number of words stored in the FIFO, excluding the word in the serializer.
REQ-011 SHALL have port o_overflow, output, 1 bit: sticky flag indicating a word was dropped.

Function
REQ-012 SHALL write i_data into the FIFO on a cycle with i_valid=1 and o_count<Depth; o_count rises on the following cycle.
REQ-013 SHALL drop i_data when i_valid=1 and o_count==Depth, including when a pop occurs in the same cycle, and SHALL set o_overflow on the next edge.
REQ-014 SHALL hold o_overflow at 1 until reset once it is set.
REQ-015 SHALL keep o_count correct for simultaneous accepted write and pop (unchanged), and SHALL never underflow or exceed Depth.
REQ-016 SHALL use wrap-around read and write pointers, modulo Depth.
REQ-017 SHALL implement a serializer FSM with states IDLE (no word held) and SEND (word held, bytes being presented).
REQ-018 SHALL, in IDLE with o_count>0, pop one word into the shift register and enter SEND; o_valid is 1 on the next cycle.
REQ-019 SHALL present bytes MSB first: byte k = word[PixelBitWidth-1-8k -: 8], for k = 0 to PixelBitWidth/8-1.
REQ-020 SHALL treat a byte as transferred on a cycle with o_valid=1 and i_ready=1; the next byte is presented on the following cycle.
REQ-021 SHALL hold o_byte and o_valid stable while o_valid=1 and i_ready=0, for any number of cycles.
REQ-022 SHALL, when the last byte of a word transfers and o_count>0, pop the next word in the same cycle and stay in SEND, so o_valid stays 1 with no gap.
REQ-023 SHALL, when the last byte of a word transfers and o_count==0, return to IDLE with o_valid=0 on the next cycle.
REQ-024 SHALL have a latency of two cycles from an accepted write into an empty FIFO with the FSM in IDLE (edge N) to o_valid=1 with the MSB byte (edge N+2).
REQ-025 SHALL ignore i_ready while o_valid=0.
REQ-026 SHALL sustain a throughput of one byte per cycle while i_ready=1 and data is available.

Reset
REQ-027 SHALL, on RST=0, immediately and asynchronously drive o_valid=0, o_byte=0, o_count=0, o_overflow=0, pointers=0, FSM=IDLE, byte index=0.
REQ-028 SHALL, when RST is asserted mid-word, discard the partial word and all FIFO contents; no byte is emitted after release until a new write.
REQ-029 SHALL ignore i_valid while RST=0 and SHALL accept writes starting on the first rising edge after release.

Verification
REQ-030 SHALL be verified by: single word 16'hA55A with i_ready held at 1 -> o_byte=8'hA5 at N+2, then 8'h5A at N+3, o_valid=0 at N+4.
REQ-031 SHALL be verified by: words 16'h1234 and 16'h5678 written back-to-back with i_ready=1 -> bytes 12, 34, 56, 78 on consecutive cycles with no o_valid gap.
REQ-032 SHALL be verified by: i_ready=0 for 5 cycles while o_byte=8'h12 -> o_byte stays 8'h12 and o_valid stays 1; 8'h34 follows one cycle after i_ready rises.
REQ-033 SHALL be verified by: i_ready=0 and Depth+2 words written, given the serializer holds 1 word -> o_count=Depth, o_overflow=1, and the last word is dropped and never emitted.
REQ-034 SHALL be verified by: o_count==Depth, simultaneous write and pop -> write dropped, o_count=Depth-1 next cycle, o_overflow=1.
REQ-035 SHALL be verified by: RST pulsed low between byte 0 and byte 1 of a word -> outputs zero asynchronously; after release o_valid stays 0 until a new write.
